// File: rtl/brush_stamper.sv
// rtl/brush_stamper.sv - square-brush write burst generator feeding pixelStore
//
// Purpose: turns one "paint at cursor" command into a row-major burst of
// single-pixel writes covering a (2r+1)x(2r+1) square clipped to the canvas.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               command strobe, honoured only when fully idle
//   cx, cy              brush centre
//   radius              brush half-width (saturated to MAX_RADIUS)
//   color               colour code to paint
//   busy                high while a command is in flight (through the done cycle)
//   done                one-cycle pulse closing every accepted command
//   brush, wx, wy       pixelStore write enable and coordinates
//   newColor            pixelStore write colour
module brush_stamper #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int MAX_RADIUS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cx,
  input  logic [7:0] cy,
  input  logic [2:0] radius,
  input  logic [2:0] color,
  output logic       busy,
  output logic       done,
  output logic       brush,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  localparam logic [8:0] W_LAST = 9'(WIDTH - 1);
  localparam logic [8:0] H_LAST = 9'(HEIGHT - 1);
  localparam logic [8:0] W_LIM  = 9'(WIDTH);
  localparam logic [8:0] H_LIM  = 9'(HEIGHT);
  localparam logic [2:0] R_MAX  = 3'(MAX_RADIUS);

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d, cy_q, cy_d;
  logic [2:0] r_q, r_d, col_q, col_d;
  logic [7:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic       busy_q, busy_d, done_q, done_d, brush_q, brush_d;
  logic [7:0] wx_q, wx_d, wy_q, wy_d;
  logic [2:0] ncol_q, ncol_d;

  // Bounds are evaluated in 9 bits: cx-r can go negative (bit 8 set) and
  // cx+r can exceed 255, both of which must clip rather than wrap.
  logic [8:0] xlo, xhi, ylo, yhi;
  logic [7:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic       off_canvas;

  always_comb begin
    xlo = {1'b0, cx_q} - {6'b0, r_q};
    xhi = {1'b0, cx_q} + {6'b0, r_q};
    ylo = {1'b0, cy_q} - {6'b0, r_q};
    yhi = {1'b0, cy_q} + {6'b0, r_q};
    xmin_c = xlo[8] ? 8'd0 : xlo[7:0];
    ymin_c = ylo[8] ? 8'd0 : ylo[7:0];
    xmax_c = (xhi > W_LAST) ? W_LAST[7:0] : xhi[7:0];
    ymax_c = (yhi > H_LAST) ? H_LAST[7:0] : yhi[7:0];
    off_canvas = ({1'b0, cx_q} >= W_LIM) || ({1'b0, cy_q} >= H_LIM);
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r_d     = r_q;
    col_d   = col_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;

    case (state_q)
      IDLE: begin
        // busy_q is still high during the cycle after DONE, which is when the
        // done pulse is visible; gating on it drops starts seen then.
        if (start && !busy_q) begin
          cx_d    = cx;
          cy_d    = cy;
          col_d   = color;
          r_d     = (radius > R_MAX) ? R_MAX : radius;
          state_d = SETUP;
        end
      end
      SETUP: begin
        xmin_d = xmin_c;
        xmax_d = xmax_c;
        ymax_d = ymax_c;
        x_d    = xmin_c;
        y_d    = ymin_c;
        state_d = off_canvas ? DONE : WRITE;
      end
      WRITE: begin
        if (x_q == xmax_q) begin
          x_d = xmin_q;
          if (y_q == ymax_q) begin
            state_d = DONE;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are a registered image of the current state, so each pixel
    // appears one cycle after the FSM visits it.
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);
    brush_d = (state_q == WRITE);
    wx_d    = (state_q == WRITE) ? x_q   : wx_q;
    wy_d    = (state_q == WRITE) ? y_q   : wy_q;
    ncol_d  = (state_q == WRITE) ? col_q : ncol_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      col_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      brush_q <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      ncol_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      col_q   <= col_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      brush_q <= brush_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      ncol_q  <= ncol_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign brush    = brush_q;
  assign wx       = wx_q;
  assign wy       = wy_q;
  assign newColor = ncol_q;

endmodule
